// File: rtl/approx_stats_pkg.sv
// Shared types and helpers for the approximate-adder error statistics block.
package approx_stats_pkg;
  localparam int W     = 8;
  localparam int CNT_W = 17;
  localparam int SUM_W = 26;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  // Saturating add on a 64-bit carrier; callers pass their own all-ones limit.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input logic [63:0] lim);
    logic [64:0] s;
    s = {1'b0, acc} + {1'b0, inc};
    return (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction
endpackage

// File: rtl/approx_err_distance.sv
// Combinational exact sum and error distance |exact - approx| (plus ED^2 when
// APPROX_STATS_SQERR_EN is defined).
module approx_err_distance #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   approx_sum,
  output logic [W:0]   ed
`ifdef APPROX_STATS_SQERR_EN
  , output logic [2*(W+1)-1:0] sq
`endif
);
  logic [W:0] exact;

  assign exact = {1'b0, a} + {1'b0, b};
  assign ed    = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);

`ifdef APPROX_STATS_SQERR_EN
  assign sq = {{(W+1){1'b0}}, ed} * {{(W+1){1'b0}}, ed};
`endif
endmodule

// File: rtl/approx_adder_error_stats.sv
// Error statistics over a run of approximate-adder samples: two-stage pipeline
// (ED, then accumulate) with a result handshake. Optional ED^2 sum: APPROX_STATS_SQERR_EN.
module approx_adder_error_stats #(
  parameter int W     = approx_stats_pkg::W,
  parameter int CNT_W = approx_stats_pkg::CNT_W,
  parameter int SUM_W = approx_stats_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       approx_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [W:0]       ed_max
`ifdef APPROX_STATS_SQERR_EN
  , output logic [2*(W+1)+CNT_W-1:0] sq_sum
`endif
);
  import approx_stats_pkg::*;

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] SUM_MAX = (64'd1 << SUM_W) - 64'd1;

  state_t     state, state_nxt;
  logic       start_pend, go, clear, accept, s1_vld;
  logic [W:0] ed, s1_ed;

  assign in_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign go        = start | start_pend;
  assign clear     = (state == IDLE) & go;

`ifdef APPROX_STATS_SQERR_EN
  localparam int          SQ_W   = 2*(W+1) + CNT_W;
  localparam logic [63:0] SQ_MAX = (64'd1 << SQ_W) - 64'd1;
  logic [2*(W+1)-1:0] sq, s1_sq;

  approx_err_distance #(.W(W)) u_ed (.a(a), .b(b), .approx_sum(approx_sum), .ed(ed), .sq(sq));
`else
  approx_err_distance #(.W(W)) u_ed (.a(a), .b(b), .approx_sum(approx_sum), .ed(ed));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)                 state_nxt = ACCUM;
      ACCUM:   if (accept && in_last)  state_nxt = DRAIN;
      DRAIN:   if (!s1_vld)            state_nxt = DONE;
      DONE:    if (res_ready)          state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // A start seen in DONE is held so an ack+start in the same cycle still launches a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DONE && start) start_pend <= 1'b1;
      else if (state == IDLE)     start_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_ed  <= '0;
`ifdef APPROX_STATS_SQERR_EN
      s1_sq  <= '0;
`endif
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_ed <= ed;
`ifdef APPROX_STATS_SQERR_EN
        s1_sq <= sq;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
`ifdef APPROX_STATS_SQERR_EN
      sq_sum     <= '0;
`endif
    end else if (s1_vld) begin
      sample_cnt <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_MAX));
      err_cnt    <= CNT_W'(sat_add(64'(err_cnt), 64'(s1_ed != '0), CNT_MAX));
      ed_sum     <= SUM_W'(sat_add(64'(ed_sum), 64'(s1_ed), SUM_MAX));
      if (s1_ed > ed_max) ed_max <= s1_ed;
`ifdef APPROX_STATS_SQERR_EN
      sq_sum     <= SQ_W'(sat_add(64'(sq_sum), 64'(s1_sq), SQ_MAX));
`endif
    end
  end
endmodule

// File: tb/tb_approx_adder_error_stats.sv
// Directed bench for approx_adder_error_stats; a second instance with narrow
// counters exercises saturation on the same stimulus.
module tb_approx_adder_error_stats;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [8:0] approx_sum = '0;

  logic        u0_in_ready, u0_res_valid, u1_in_ready, u1_res_valid;
  logic [16:0] u0_sample_cnt, u0_err_cnt;
  logic [25:0] u0_ed_sum;
  logic [8:0]  u0_ed_max, u1_ed_max;
  logic [3:0]  u1_sample_cnt, u1_err_cnt;
  logic [7:0]  u1_ed_sum;
`ifdef APPROX_STATS_SQERR_EN
  logic [34:0] u0_sq_sum;
  logic [21:0] u1_sq_sum;
`endif

  int n_vec = 0, n_err = 0;
  longint m_cnt, m_err, m_sum, m_max, m_sq;

  always #5 clk = ~clk;

  approx_adder_error_stats u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(u0_in_ready),
    .in_last(in_last), .a(a), .b(b), .approx_sum(approx_sum), .res_valid(u0_res_valid),
    .res_ready(res_ready), .sample_cnt(u0_sample_cnt), .err_cnt(u0_err_cnt),
    .ed_sum(u0_ed_sum), .ed_max(u0_ed_max)
`ifdef APPROX_STATS_SQERR_EN
    , .sq_sum(u0_sq_sum)
`endif
  );

  approx_adder_error_stats #(.CNT_W(4), .SUM_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(u1_in_ready),
    .in_last(in_last), .a(a), .b(b), .approx_sum(approx_sum), .res_valid(u1_res_valid),
    .res_ready(res_ready), .sample_cnt(u1_sample_cnt), .err_cnt(u1_err_cnt),
    .ed_sum(u1_ed_sum), .ed_max(u1_ed_max)
`ifdef APPROX_STATS_SQERR_EN
    , .sq_sum(u1_sq_sum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [7:0] x, input logic [7:0] y, input logic [8:0] s, input logic l);
    in_valid = 1'b1; a = x; b = y; approx_sum = s; in_last = l;
    tick();
  endtask

  task automatic start_run();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // After the in_last beat: res_valid low one cycle later, high the cycle after.
  task automatic finish_run(input string tag);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk({tag, ".res_valid_early"}, u0_res_valid, 0);
    tick();
    chk({tag, ".res_valid"}, u0_res_valid, 1);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ack.res_valid", u0_res_valid, 0);
  endtask

  // Golden lower-part-OR approximate adder: low 3 bits OR'd, upper part exact, no carry-in.
  function automatic logic [8:0] loa(input logic [7:0] x, input logic [7:0] y);
    logic [5:0] hi;
    hi = {1'b0, x[7:3]} + {1'b0, y[7:3]};
    return {hi, x[2:0] | y[2:0]};
  endfunction

  task automatic model_add(input logic [7:0] x, input logic [7:0] y, input logic [8:0] s);
    longint ex, ap, d;
    ex = longint'(x) + longint'(y);
    ap = longint'(s);
    d  = (ex > ap) ? ex - ap : ap - ex;
    m_cnt++; m_sum += d; m_sq += d * d;
    if (d != 0) m_err++;
    if (d > m_max) m_max = d;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sq = 0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst.in_ready", u0_in_ready, 0);
    chk("rst.res_valid", u0_res_valid, 0);
    chk("rst.sample_cnt", u0_sample_cnt, 0);
    chk("rst.ed_max", u0_ed_max, 0);
    #5 rst_n = 1'b1;
    tick();

    // mid-run asynchronous reset
    start_run();
    chk("run.in_ready", u0_in_ready, 1);
    repeat (5) beat(8'hFF, 8'h01, 9'h0F0, 1'b0);
    chk("midrun.sample_cnt", u0_sample_cnt, 4);
    chk("midrun.ed_sum", u0_ed_sum, 64);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.in_ready", u0_in_ready, 0);
    chk("arst.res_valid", u0_res_valid, 0);
    chk("arst.sample_cnt", u0_sample_cnt, 0);
    chk("arst.err_cnt", u0_err_cnt, 0);
    chk("arst.ed_sum", u0_ed_sum, 0);
    chk("arst.ed_max", u0_ed_max, 0);
    #2 rst_n = 1'b1;
    tick();

    // exact samples
    start_run();
    beat(8'h80, 8'h80, 9'h100, 1'b0);
    beat(8'h01, 8'h02, 9'h003, 1'b1);
    finish_run("exact");
    chk("exact.sample_cnt", u0_sample_cnt, 2);
    chk("exact.err_cnt", u0_err_cnt, 0);
    chk("exact.ed_sum", u0_ed_sum, 0);
    chk("exact.ed_max", u0_ed_max, 0);
    ack();
    chk("ack.in_ready", u0_in_ready, 0);

    // single errors, ED 16 and 5
    start_run();
    beat(8'hFF, 8'h01, 9'h0F0, 1'b0);
    beat(8'h10, 8'h10, 9'h025, 1'b1);
    finish_run("errs");
    chk("errs.sample_cnt", u0_sample_cnt, 2);
    chk("errs.err_cnt", u0_err_cnt, 2);
    chk("errs.ed_sum", u0_ed_sum, 21);
    chk("errs.ed_max", u0_ed_max, 16);
`ifdef APPROX_STATS_SQERR_EN
    chk("errs.sq_sum", u0_sq_sum, 281);
`endif

    // results hold while the consumer stalls
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.res_valid", u0_res_valid, 1);
      chk("hold.ed_sum", u0_ed_sum, 21);
    end
    // ack and start together: start is held and taken from IDLE next cycle
    res_ready = 1'b1; start = 1'b1;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("ackstart.res_valid", u0_res_valid, 0);
    chk("ackstart.in_ready", u0_in_ready, 0);
    tick();
    chk("pend.in_ready", u0_in_ready, 1);
    chk("pend.sample_cnt", u0_sample_cnt, 0);
    chk("pend.ed_sum", u0_ed_sum, 0);

    // 20 erroneous beats; a stray start mid-run must not clear anything
    for (int i = 0; i < 20; i++) begin
      start = (i == 10);
      beat(8'hFF, 8'h01, 9'h0F0, i == 19);
    end
    start = 1'b0;
    finish_run("sat");
    chk("sat.u0.sample_cnt", u0_sample_cnt, 20);
    chk("sat.u0.err_cnt", u0_err_cnt, 20);
    chk("sat.u0.ed_sum", u0_ed_sum, 320);
    chk("sat.u1.sample_cnt", u1_sample_cnt, 15);
    chk("sat.u1.err_cnt", u1_err_cnt, 15);
    chk("sat.u1.ed_sum", u1_ed_sum, 255);
    chk("sat.u1.ed_max", u1_ed_max, 16);
`ifdef APPROX_STATS_SQERR_EN
    chk("sat.u0.sq_sum", u0_sq_sum, 5120);
`endif
    ack();

    // full 256x256 sweep against the golden approximate adder
    model_clear();
    start_run();
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++) begin
        model_add(i[7:0], j[7:0], loa(i[7:0], j[7:0]));
        beat(i[7:0], j[7:0], loa(i[7:0], j[7:0]), (i == 255) && (j == 255));
      end
    finish_run("sweep");
    chk("sweep.sample_cnt", u0_sample_cnt, 65536);
    chk("sweep.err_cnt", u0_err_cnt, m_err);
    chk("sweep.ed_sum", u0_ed_sum, m_sum);
    chk("sweep.ed_max", u0_ed_max, m_max);
    chk("sweep.u1.sample_cnt", u1_sample_cnt, 15);
`ifdef APPROX_STATS_SQERR_EN
    chk("sweep.sq_sum", u0_sq_sum, m_sq);
`endif
    ack();

    // beats offered in IDLE are ignored; then a run with random valid gaps
    repeat (3) beat(8'hFF, 8'h01, 9'h0F0, 1'b1);
    model_clear();
    start_run();
    for (int k = 0; k < 200; k++) begin
      logic [7:0] x, y;
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_last = $urandom_range(0, 1) == 1;
        a = 8'($urandom); b = 8'($urandom); approx_sum = 9'($urandom);
        tick();
      end
      x = 8'($urandom); y = 8'($urandom);
      model_add(x, y, loa(x, y));
      beat(x, y, loa(x, y), k == 199);
    end
    finish_run("gaps");
    chk("gaps.sample_cnt", u0_sample_cnt, m_cnt);
    chk("gaps.err_cnt", u0_err_cnt, m_err);
    chk("gaps.ed_sum", u0_ed_sum, m_sum);
    chk("gaps.ed_max", u0_ed_max, m_max);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
